gaplus_video_timing: RTL

- Upstream raster timing generator for the Gaplus core. Runs on the 49.125 MHz master clock.
- Derives a 6.14 MHz pixel clock-enable and produces the PH/PV screen counters consumed by the core's video module.
- Also produces blanking, sync and a frame-start pulse for the MiSTer video output path.
- Sync position can be shifted per frame by a user offset without tearing.

---
 rtl/gaplus_video_pkg.sv | 20 ++
 rtl/gaplus_video_timing_if.sv | 25 ++
 rtl/gaplus_sync_window.sv | 24 ++
 rtl/gaplus_video_timing.sv | 124 ++++++++++++
 4 files changed

// File: rtl/gaplus_video_pkg.sv
// Gaplus raster timing: default timing constants and shared counter types.
package gaplus_video_pkg;

  localparam int unsigned H_TOTAL      = 384;
  localparam int unsigned H_VIS        = 288;
  localparam int unsigned H_SYNC_START = 304;
  localparam int unsigned H_SYNC_LEN   = 32;
  localparam int unsigned V_TOTAL      = 264;
  localparam int unsigned V_VIS        = 224;
  localparam int unsigned V_SYNC_START = 240;
  localparam int unsigned V_SYNC_LEN   = 3;
  localparam int unsigned CE_DIV       = 8;

  localparam int unsigned CNT_W = 9;
  localparam int unsigned OFS_W = 4;

  typedef logic [CNT_W-1:0]        cnt_t;
  typedef logic signed [OFS_W-1:0] ofs_t;

endpackage

// File: rtl/gaplus_video_timing_if.sv
// Raster timing bundle: sync offsets in, pixel enable / counters / flags out.
interface gaplus_video_timing_if;
  import gaplus_video_pkg::*;

  logic [OFS_W-1:0] HOFS;
  logic [OFS_W-1:0] VOFS;
  logic             CE_PIX;
  logic [CNT_W-1:0] PH;
  logic [CNT_W-1:0] PV;
  logic             HBLANK;
  logic             VBLANK;
  logic             HSYNC;
  logic             VSYNC;
  logic             FRAME_START;

  modport master (
    input  HOFS, VOFS,
    output CE_PIX, PH, PV, HBLANK, VBLANK, HSYNC, VSYNC, FRAME_START
  );

  modport slave (
    output HOFS, VOFS,
    input  CE_PIX, PH, PV, HBLANK, VBLANK, HSYNC, VSYNC, FRAME_START
  );
endinterface

// File: rtl/gaplus_sync_window.sv
// In-window decode: count lies in [start+ofs, start+ofs+len-1], 10-bit signed.
module gaplus_sync_window
  import gaplus_video_pkg::*;
(
  input  cnt_t count,
  input  cnt_t start,
  input  ofs_t ofs,
  input  cnt_t len,
  output logic in_win
);
  localparam int unsigned W = CNT_W + 1;

  logic signed [W-1:0] cnt_s;
  logic signed [W-1:0] lo_s;
  logic signed [W-1:0] hi_s;

  // Signed window bounds and compare
  always_comb begin
    cnt_s  = signed'({1'b0, count});
    lo_s   = signed'({1'b0, start}) + signed'({{(W-OFS_W){ofs[OFS_W-1]}}, ofs});
    hi_s   = lo_s + signed'({1'b0, len}) - signed'(W'(1));
    in_win = (cnt_s >= lo_s) && (cnt_s <= hi_s);
  end
endmodule

// File: rtl/gaplus_video_timing.sv
// Gaplus raster timing: pixel enable divider, PH/PV counters, blank/sync/frame flags.
module gaplus_video_timing #(
  parameter int unsigned H_TOTAL      = gaplus_video_pkg::H_TOTAL,
  parameter int unsigned H_VIS        = gaplus_video_pkg::H_VIS,
  parameter int unsigned H_SYNC_START = gaplus_video_pkg::H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = gaplus_video_pkg::H_SYNC_LEN,
  parameter int unsigned V_TOTAL      = gaplus_video_pkg::V_TOTAL,
  parameter int unsigned V_VIS        = gaplus_video_pkg::V_VIS,
  parameter int unsigned V_SYNC_START = gaplus_video_pkg::V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = gaplus_video_pkg::V_SYNC_LEN
) (
  input  logic                         MCLK,
  input  logic                         RESET_N,
  gaplus_video_timing_if.master        vid
);
  import gaplus_video_pkg::cnt_t;
  import gaplus_video_pkg::ofs_t;

  localparam logic [2:0] DIV_LAST = 3'(gaplus_video_pkg::CE_DIV - 1);

  logic [2:0] div_q, div_d;
  logic       ce_q, ce_d;
  cnt_t       ph_q, ph_d, pv_q, pv_d;
  ofs_t       hofs_q, hofs_d, vofs_q, vofs_d;
  logic       hblank_q, hblank_d, vblank_q, vblank_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       fstart_q, fstart_d;
  logic       tick, h_end, v_end;
  logic       hs_win, vs_win;

  // Divider, counters, end-of-frame offset latch and frame-start pulse
  always_comb begin
    tick     = (div_q == DIV_LAST);
    h_end    = (ph_q == cnt_t'(H_TOTAL - 1));
    v_end    = (pv_q == cnt_t'(V_TOTAL - 1));
    div_d    = div_q + 3'd1;
    ce_d     = tick;
    ph_d     = ph_q;
    pv_d     = pv_q;
    hofs_d   = hofs_q;
    vofs_d   = vofs_q;
    fstart_d = 1'b0;
    if (tick) begin
      ph_d = h_end ? '0 : ph_q + cnt_t'(1);
      if (h_end) begin
        pv_d = v_end ? '0 : pv_q + cnt_t'(1);
        if (v_end) begin
          hofs_d   = ofs_t'(vid.HOFS);
          vofs_d   = ofs_t'(vid.VOFS);
          fstart_d = 1'b1;
        end
      end
    end
  end

  // Decodes use next-count and next-offset values so they land with the count
  gaplus_sync_window u_hwin (
    .count  (ph_d),
    .start  (cnt_t'(H_SYNC_START)),
    .ofs    (hofs_d),
    .len    (cnt_t'(H_SYNC_LEN)),
    .in_win (hs_win)
  );

  gaplus_sync_window u_vwin (
    .count  (pv_d),
    .start  (cnt_t'(V_SYNC_START)),
    .ofs    (vofs_d),
    .len    (cnt_t'(V_SYNC_LEN)),
    .in_win (vs_win)
  );

  // Blank/sync flags updated on pixel enables; VSYNC only at line wrap
  always_comb begin
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    if (tick) begin
      hblank_d = (ph_d >= cnt_t'(H_VIS));
      vblank_d = (pv_d >= cnt_t'(V_VIS));
      hsync_d  = hs_win;
      if (h_end) vsync_d = vs_win;
    end
  end

  // State registers
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q    <= '0;
      ce_q     <= 1'b0;
      ph_q     <= '0;
      pv_q     <= '0;
      hofs_q   <= '0;
      vofs_q   <= '0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      ce_q     <= ce_d;
      ph_q     <= ph_d;
      pv_q     <= pv_d;
      hofs_q   <= hofs_d;
      vofs_q   <= vofs_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fstart_q <= fstart_d;
    end
  end

  assign vid.CE_PIX      = ce_q;
  assign vid.PH          = ph_q;
  assign vid.PV          = pv_q;
  assign vid.HBLANK      = hblank_q;
  assign vid.VBLANK      = vblank_q;
  assign vid.HSYNC       = hsync_q;
  assign vid.VSYNC       = vsync_q;
  assign vid.FRAME_START = fstart_q;
endmodule
